// File: rtl/core_pkg.sv
// Shared definitions for the WebAssembly-subset stack core: opcodes,
// trap codes, FSM state encoding and operand stack geometry.
package core_pkg;

   localparam int         STACK_DEPTH = 16;
   localparam int         SP_W        = 5;
   localparam logic [4:0] SP_FULL     = 5'd16;

   localparam logic [3:0] MEM_EXTRA_FULL = 4'd15;

   localparam logic [7:0] OP_UNREACHABLE = 8'h00;
   localparam logic [7:0] OP_NOP         = 8'h01;
   localparam logic [7:0] OP_END         = 8'h0B;
   localparam logic [7:0] OP_DROP        = 8'h1A;
   localparam logic [7:0] OP_I32_CONST   = 8'h41;
   localparam logic [7:0] OP_I64_CONST   = 8'h42;
   localparam logic [7:0] OP_I32_EQZ     = 8'h45;
   localparam logic [7:0] OP_I32_EQ      = 8'h46;
   localparam logic [7:0] OP_I64_EQZ     = 8'h50;
   localparam logic [7:0] OP_I64_EQ      = 8'h51;
   localparam logic [7:0] OP_I32_ADD     = 8'h6A;
   localparam logic [7:0] OP_I32_SUB     = 8'h6B;
   localparam logic [7:0] OP_I64_ADD     = 8'h7C;
   localparam logic [7:0] OP_I64_SUB     = 8'h7D;

   localparam logic [3:0] TRAP_NONE        = 4'd0;
   localparam logic [3:0] TRAP_UNREACHABLE = 4'd1;
   localparam logic [3:0] TRAP_ILLEGAL     = 4'd2;
   localparam logic [3:0] TRAP_UNDERFLOW   = 4'd3;
   localparam logic [3:0] TRAP_OVERFLOW    = 4'd4;
   localparam logic [3:0] TRAP_MEM         = 4'd5;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   // i32 results live zero-extended in the 64-bit stack slots.
   function automatic logic [63:0] zext32(input logic [31:0] v);
      return {32'd0, v};
   endfunction

endpackage

// File: rtl/leb128_decode.sv
// Combinational signed LEB128 decoder. The window holds the immediate's
// first byte in [7:0]. Up to 10 bytes are examined; len is the encoded
// length in bytes, or 0 when no terminating byte appears within 10 bytes.
module leb128_decode (
   input  logic [127:0] window,
   output logic [63:0]  value,
   output logic [3:0]   len
);

   logic [63:0] value_s;
   logic [3:0]  len_s;
   logic        done_s;
   logic        sign_s;
   logic        unused_window_s;

   assign unused_window_s = ^window[127:80];

   // Accumulate 7-bit groups up to the first byte without continuation bit, then sign-extend.
   always_comb begin
      value_s = 64'd0;
      len_s   = 4'd0;
      done_s  = 1'b0;
      sign_s  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!done_s) begin
            value_s = value_s | ({57'd0, window[8*i +: 7]} << (7*i));
            if (window[8*i+7] == 1'b0) begin
               done_s = 1'b1;
               len_s  = 4'(i + 1);
               sign_s = window[8*i+6];
            end else begin
               done_s = 1'b0;
            end
         end else begin
            done_s = 1'b1;
         end
      end
      if (done_s && sign_s && (len_s < 4'd10)) begin
         value_s = value_s | ({64{1'b1}} << (7*int'(len_s)));
      end else begin
         value_s = value_s;
      end
   end

   assign value = value_s;
   assign len   = len_s;

endmodule

// File: rtl/core.sv
// WebAssembly-subset stack machine: FETCH presents pc with a 16-byte
// window to the synchronous ROM, EXEC decodes the returned bytes and
// updates the 16 x 64-bit operand stack. Any trap or `end` halts the core
// until reset. Optional macro CORE_I64_EN adds the i64 const/eqz/eq/add/sub
// opcodes; without it those opcodes trap as illegal.
module core
   import core_pkg::*;
#(
   parameter int MEM_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   output logic [63:0]          result,
   output logic                 result_empty,
   output logic [3:0]           trap,
   output logic [MEM_DEPTH:0]   mem_addr,
   output logic [3:0]           mem_extra,
   input  logic [127:0]         mem_data,
   input  logic                 mem_error
);

   localparam int AW = MEM_DEPTH + 1;

   // Declaration initialisers match the reset values so that the core
   // starts correctly even if reset is never asserted.
   state_t          state_r = ST_FETCH;
   logic [AW-1:0]   pc_r    = {AW{1'b0}};
   logic [SP_W-1:0] sp_r    = 5'd0;
   logic [3:0]      trap_r  = 4'd0;
   logic [63:0]     stack_r [STACK_DEPTH];

   logic [7:0]      opcode_s;
   logic [63:0]     leb_val_s;
   logic [3:0]      leb_len_s;
   logic [4:0]      sp_m1_s;
   logic [4:0]      sp_m2_s;
   logic [63:0]     top_s;
   logic [63:0]     sec_s;
   logic [1:0]      pops_s;
   logic            push_s;
   logic [63:0]     push_val_s;
   logic [3:0]      pc_step_s;
   logic [3:0]      op_trap_s;
   logic            end_s;
   logic [4:0]      sp_base_s;
   logic [4:0]      sp_after_s;
   logic [3:0]      exec_trap_s;

   assign opcode_s = mem_data[7:0];

   leb128_decode u_leb (
      .window ({8'd0, mem_data[127:8]}),
      .value  (leb_val_s),
      .len    (leb_len_s)
   );

   assign sp_m1_s    = sp_r - 5'd1;
   assign sp_m2_s    = sp_r - 5'd2;
   assign top_s      = stack_r[sp_m1_s[3:0]];
   assign sec_s      = stack_r[sp_m2_s[3:0]];
   assign sp_base_s  = sp_r - {3'd0, pops_s};
   assign sp_after_s = sp_base_s + {4'd0, push_s};

`ifndef CORE_I64_EN
   logic unused_hi_s;
   assign unused_hi_s = ^{leb_val_s[63:32], sec_s[63:32]};
`endif

   // Decode the opcode byte into stack effect, pushed value, pc step and opcode-level trap.
   always_comb begin
      pops_s     = 2'd0;
      push_s     = 1'b0;
      push_val_s = 64'd0;
      pc_step_s  = 4'd1;
      op_trap_s  = TRAP_NONE;
      end_s      = 1'b0;
      case (opcode_s)
         OP_UNREACHABLE: op_trap_s = TRAP_UNREACHABLE;
         OP_NOP:         pc_step_s = 4'd1;
         OP_END:         end_s = 1'b1;
         OP_DROP:        pops_s = 2'd1;
         OP_I32_CONST: begin
            if ((leb_len_s != 4'd0) && (leb_len_s <= 4'd5)) begin
               push_s     = 1'b1;
               push_val_s = zext32(leb_val_s[31:0]);
               pc_step_s  = 4'd1 + leb_len_s;
            end else begin
               op_trap_s  = TRAP_ILLEGAL;
            end
         end
         OP_I32_EQZ: begin
            pops_s     = 2'd1;
            push_s     = 1'b1;
            push_val_s = zext32({31'd0, top_s[31:0] == 32'd0});
         end
         OP_I32_EQ: begin
            pops_s     = 2'd2;
            push_s     = 1'b1;
            push_val_s = zext32({31'd0, sec_s[31:0] == top_s[31:0]});
         end
         OP_I32_ADD: begin
            pops_s     = 2'd2;
            push_s     = 1'b1;
            push_val_s = zext32(sec_s[31:0] + top_s[31:0]);
         end
         OP_I32_SUB: begin
            pops_s     = 2'd2;
            push_s     = 1'b1;
            push_val_s = zext32(sec_s[31:0] - top_s[31:0]);
         end
`ifdef CORE_I64_EN
         OP_I64_CONST: begin
            if (leb_len_s != 4'd0) begin
               push_s     = 1'b1;
               push_val_s = leb_val_s;
               pc_step_s  = 4'd1 + leb_len_s;
            end else begin
               op_trap_s  = TRAP_ILLEGAL;
            end
         end
         OP_I64_EQZ: begin
            pops_s     = 2'd1;
            push_s     = 1'b1;
            push_val_s = {63'd0, top_s == 64'd0};
         end
         OP_I64_EQ: begin
            pops_s     = 2'd2;
            push_s     = 1'b1;
            push_val_s = {63'd0, sec_s == top_s};
         end
         OP_I64_ADD: begin
            pops_s     = 2'd2;
            push_s     = 1'b1;
            push_val_s = sec_s + top_s;
         end
         OP_I64_SUB: begin
            pops_s     = 2'd2;
            push_s     = 1'b1;
            push_val_s = sec_s - top_s;
         end
`endif
         default: op_trap_s = TRAP_ILLEGAL;
      endcase
   end

   // Prioritise the trap cause: fetch error, then opcode trap, then stack bounds.
   always_comb begin
      exec_trap_s = TRAP_NONE;
      if (mem_error) begin
         exec_trap_s = TRAP_MEM;
      end else if (op_trap_s != TRAP_NONE) begin
         exec_trap_s = op_trap_s;
      end else if ({3'd0, pops_s} > sp_r) begin
         exec_trap_s = TRAP_UNDERFLOW;
      end else if (sp_after_s > SP_FULL) begin
         exec_trap_s = TRAP_OVERFLOW;
      end else begin
         exec_trap_s = TRAP_NONE;
      end
   end

   // Instruction sequencer: FETCH/EXEC alternation, stack and pc commit, halt on trap or end.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_FETCH;
         pc_r    <= {AW{1'b0}};
         sp_r    <= 5'd0;
         trap_r  <= TRAP_NONE;
      end else begin
         case (state_r)
            ST_FETCH: state_r <= ST_EXEC;
            ST_EXEC: begin
               if (exec_trap_s != TRAP_NONE) begin
                  trap_r  <= exec_trap_s;
                  state_r <= ST_HALT;
               end else if (end_s) begin
                  state_r <= ST_HALT;
               end else begin
                  if (push_s) begin
                     stack_r[sp_base_s[3:0]] <= push_val_s;
                  end
                  sp_r    <= sp_after_s;
                  pc_r    <= pc_r + AW'(pc_step_s);
                  state_r <= ST_FETCH;
               end
            end
            ST_HALT:  state_r <= ST_HALT;
            default:  state_r <= ST_FETCH;
         endcase
      end
   end

   assign mem_addr     = pc_r;
   assign mem_extra    = MEM_EXTRA_FULL;
   assign trap         = trap_r;
   assign result_empty = (sp_r == 5'd0);
   assign result       = (sp_r == 5'd0) ? 64'd0 : top_s;

endmodule

// File: tb/tb_core.sv
// Directed bench for core: behavioural synchronous ROM, a table of short
// programs with hand-computed final outputs, and hand-written sequences
// for power-up without reset, stack overflow, fetch error and reset corners.
module tb_core;

   localparam int MEM_DEPTH = 6;
   localparam int ROM_BYTES = 128;

   logic               clk          = 1'b0;
   logic               reset        = 1'b0;
   logic [63:0]        result;
   logic               result_empty;
   logic [3:0]         trap;
   logic [MEM_DEPTH:0] mem_addr;
   logic [3:0]         mem_extra;
   logic [127:0]       mem_data     = 128'd0;
   logic               mem_error    = 1'b0;

   logic [7:0]         rom [ROM_BYTES];

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [127:0] prog;
      int           n;
      logic [63:0]  exp_result;
      logic         exp_empty;
      logic [3:0]   exp_trap;
   } vec_t;

   localparam int NVEC = 17;
   vec_t vecs [NVEC];

   core #(.MEM_DEPTH(MEM_DEPTH)) dut (
      .clk          (clk),
      .reset        (reset),
      .result       (result),
      .result_empty (result_empty),
      .trap         (trap),
      .mem_addr     (mem_addr),
      .mem_extra    (mem_extra),
      .mem_data     (mem_data),
      .mem_error    (mem_error)
   );

   always #5 clk = ~clk;

   // Synchronous ROM: window and bounds error valid one cycle after the address.
   always @(posedge clk) begin
      for (int i = 0; i < 16; i++) begin
         mem_data[8*i +: 8] <= rom[(int'(mem_addr) + i) % ROM_BYTES];
      end
      mem_error <= (int'(mem_addr) + int'(mem_extra)) >= ROM_BYTES;
   end

   task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", what, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_rom(input logic [7:0] fill);
      for (int i = 0; i < ROM_BYTES; i++) rom[i] = fill;
   endtask

   // Program bytes written in reading order, most significant byte first.
   task automatic load(input logic [127:0] prog, input int n);
      clear_rom(8'h00);
      for (int i = 0; i < n; i++) rom[i] = prog[8*(n-1-i) +: 8];
   endtask

   task automatic do_reset;
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   task automatic check_out(input string tag, input logic [63:0] r, input logic e, input logic [3:0] t);
      check({tag, " result"}, result, r);
      check({tag, " empty"}, {63'd0, result_empty}, {63'd0, e});
      check({tag, " trap"}, {60'd0, trap}, {60'd0, t});
   endtask

   initial begin
      // Power-up without reset: 41 00 45 0B must end with 1 on the stack.
      load(128'h41_00_45_0B, 4);
      #1;
      check_out("powerup", 64'd0, 1'b1, 4'd0);
      check("powerup mem_addr", {57'd0, mem_addr}, 64'd0);
      check("powerup mem_extra", {60'd0, mem_extra}, 64'd15);
      tick(9);
      check_out("noreset", 64'd1, 1'b0, 4'd0);
      tick(10);
      check_out("noreset hold", 64'd1, 1'b0, 4'd0);
      check("noreset hold mem_addr", {57'd0, mem_addr}, 64'd3);

      vecs[0]  = '{128'h41_05_45_0B,             4,  64'd0,           1'b0, 4'd0};
      vecs[1]  = '{128'h41_7F_41_02_6A_0B,       6,  64'd1,           1'b0, 4'd0};
      vecs[2]  = '{128'h45_0B,                   2,  64'd0,           1'b1, 4'd3};
      vecs[3]  = '{128'hFF,                      1,  64'd0,           1'b1, 4'd2};
      vecs[4]  = '{128'h00,                      1,  64'd0,           1'b1, 4'd1};
      vecs[5]  = '{128'h41_7F_41_01_6B_0B,       6,  64'hFFFF_FFFE,   1'b0, 4'd0};
      vecs[6]  = '{128'h41_80_01_0B,             4,  64'h80,          1'b0, 4'd0};
      vecs[7]  = '{128'h41_03_41_03_46_0B,       6,  64'd1,           1'b0, 4'd0};
      vecs[8]  = '{128'h41_03_1A_1A_0B,          5,  64'd0,           1'b1, 4'd3};
      vecs[9]  = '{128'h41_05_6A_0B,             4,  64'd5,           1'b0, 4'd3};
      vecs[10] = '{128'h41_80_80_80_80_08_0B,    7,  64'h8000_0000,   1'b0, 4'd0};
      vecs[11] = '{128'h41_40_0B,                3,  64'hFFFF_FFC0,   1'b0, 4'd0};
      vecs[12] = '{128'h41_FF_FF_FF_FF_07_41_01_6A_0B, 10, 64'h8000_0000, 1'b0, 4'd0};
`ifdef CORE_I64_EN
      vecs[13] = '{128'h42_01_0B,                3,  64'd1,           1'b0, 4'd0};
`else
      vecs[13] = '{128'h42_01_0B,                3,  64'd0,           1'b1, 4'd2};
`endif
      vecs[14] = '{128'h41_01_41_02_46_0B,       6,  64'd0,           1'b0, 4'd0};
      vecs[15] = '{128'h01_0B,                   2,  64'd0,           1'b1, 4'd0};
      vecs[16] = '{128'h41_09_FE,                3,  64'd9,           1'b0, 4'd2};

      for (int v = 0; v < NVEC; v++) begin
         reset = 1'b1;
         load(vecs[v].prog, vecs[v].n);
         tick(2);
         reset = 1'b0;
         tick(60);
         check_out($sformatf("vec%0d", v), vecs[v].exp_result, vecs[v].exp_empty, vecs[v].exp_trap);
      end

      // Seventeen pushes of 1..17: the last overflows and leaves 16 on top.
      reset = 1'b1;
      clear_rom(8'h00);
      for (int k = 0; k < 17; k++) begin
         rom[2*k]   = 8'h41;
         rom[2*k+1] = 8'(k + 1);
      end
      rom[34] = 8'h0B;
      tick(2);
      reset = 1'b0;
      tick(80);
      check_out("overflow", 64'd16, 1'b0, 4'd4);

      // All-nop ROM runs into the end of the ROM: window at 113 exceeds 127.
      reset = 1'b1;
      clear_rom(8'h01);
      tick(2);
      reset = 1'b0;
      tick(300);
      check_out("memerr", 64'd0, 1'b1, 4'd5);
      check("memerr mem_addr", {57'd0, mem_addr}, 64'd113);

      // Reset pulsed mid-run restarts the program from address 0.
      reset = 1'b1;
      load(128'h41_03_1A_0B, 4);
      tick(2);
      reset = 1'b0;
      tick(2);
      check_out("midrun pre", 64'd3, 1'b0, 4'd0);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_out("midrun reset", 64'd0, 1'b1, 4'd0);
      check("midrun mem_addr", {57'd0, mem_addr}, 64'd0);
      tick(20);
      check_out("midrun final", 64'd0, 1'b1, 4'd0);

      // Reset beats a trap raised in the same cycle, and clears a halted trap.
      reset = 1'b1;
      load(128'h00, 1);
      tick(2);
      reset = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check("reset wins trap", {60'd0, trap}, 64'd0);
      tick(2);
      check("unreachable after reset", {60'd0, trap}, 64'd1);
      tick(20);
      check("unreachable held", {60'd0, trap}, 64'd1);
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      check_out("reset from halt", 64'd0, 1'b1, 4'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
